stopwatch_dp2: RTL and testbench
================================

Name: stopwatch_dp2

Overview:
Parametrised next-generation stopwatch/timer datapath. It provides a cascaded msec/sec/min/hour count driven by an internal prescaled tick. It adds countdown mode with preload and a done pulse, lap-freeze of the outputs, and a configurable hour modulus. It sits between the stopwatch control unit (run/stop, clear, lap, mode, load) and the FND/UART display formatters.

Parameters:
- SYS_CLK_HZ, 100_000_000, input clock frequency.
- TICK_HZ, 100, base tick rate. DIV = SYS_CLK_HZ/TICK_HZ, which must be an integer ≥2.
- MSEC_COUNT, 100, modulus of the sub-second field. Must equal TICK_HZ.
- HOUR_COUNT, 24, modulus of the hour field.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- i_runstop  in  1  level. 1 = counting enabled.
- i_clear  in  1  pulse. Zeroes counters, prescaler and lap state.
- i_mode  in  1  level. 0 = count up (stopwatch), 1 = count down (timer).
- i_load  in  1  pulse. Loads the preset fields below into the counters.
- i_lap  in  1  pulse. Toggles lap freeze.
- i_ld_msec  in  7  preset msec.
- i_ld_sec  in  6  preset sec.
- i_ld_min  in  6  preset min.
- i_ld_hour  in  5  preset hour.
- msec  out  7  displayed msec.
- sec  out  6  displayed sec.
- min  out  6  displayed min.
- hour  out  5  displayed hour.
- o_lap_active  out  1  1 while outputs are frozen.
- o_done  out  1  one-cycle pulse when a countdown reaches 00:00:00.00.

Behaviour:
- Reset (rst=0, async): all counters, prescaler, snapshot, lap flag and o_done are 0. Outputs read 0.
- Prescaler: counts 0..DIV-1 only while i_runstop=1. It holds its value while stopped and does not restart. The tick is asserted for one cycle when the count is DIV-1, then the prescaler wraps to 0.
- Counters update on the clk edge where the tick is high. The new value is visible the cycle after the tick.
- Up mode:
  - msec increments. At MSEC_COUNT-1 it wraps to 0 and carries into sec.
  - sec wraps at 59 and carries into min.
  - min wraps at 59 and carries into hour.
  - hour wraps at HOUR_COUNT-1 to 0. Full rollover reads 0, with no flag.
- Down mode:
  - msec decrements. At 0 it reloads MSEC_COUNT-1 and borrows from sec. Same rule for sec and min (reload 59).
  - hour borrow at 0 never occurs because of the saturation below.
  - When all fields are 0, ticks are ignored and the counters hold at 0.
  - The tick that makes all fields 0 raises o_done for exactly one cycle.
  - Entering down mode already at 0 produces no o_done.
- Load: on i_load, counters take the presets. Presets are clamped to modulus-1 if out of range. The prescaler is zeroed. o_done is not asserted.
- Priority in a single cycle: i_clear > i_load > tick. i_clear and i_load both win over a coincident tick, which is dropped.
- Mode change mid-count: takes effect on the next tick. Values are kept.
- Lap:
  - i_lap while not frozen copies the live counters into the snapshot and sets o_lap_active.
  - i_lap while frozen clears o_lap_active.
  - The outputs mux the snapshot when frozen and the live counters otherwise, combinationally from registers.
  - Live counting continues during the freeze.
  - i_clear also clears o_lap_active.
- i_lap coincident with a tick: the snapshot takes the pre-tick value.
- Tick carry chain is same-cycle: a msec wrap and the sec increment occur on the same edge, so there is no ripple latency.

Decomposition:
- Package stopwatch_pkg holds:
  - width constants MSEC_W=7, SEC_W=6, MIN_W=6, HOUR_W=5;
  - SEC_COUNT=60, MIN_COUNT=60;
  - mode encoding MODE_UP=0, MODE_DOWN=1.
- Sub-module sw_updown_counter, instantiated 4× with parameters BIT_WIDTH and COUNT:
  - inputs i_tick, i_dir, i_clear, i_load, i_ld_val;
  - outputs o_val and o_carry (up wrap or down borrow, combinational, qualified by i_tick).
- Prescaler, zero detect, saturation gating, o_done and lap logic stay in the top module.

Test Plan (SYS_CLK_HZ=1000, TICK_HZ=100, so DIV=10):
- Reset release, i_runstop=1 for 1000 clk → msec=0, sec=1. The first tick occurs at clk cycle 10 after run.
- Up mode, load 23:59:59.99, run 10 clk → all outputs 0, o_done stays 0.
- Down mode, load 00:00:00.03, run → msec goes 2,1,0. o_done pulses one cycle on the third tick. Further ticks leave msec=0 with no more o_done.
- Run, pulse i_lap at sec=2, run 500 clk → outputs frozen at the sec=2 value while the live count advances. A second i_lap shows sec=2/msec≈50+ and o_lap_active=0.
- Stop after 5 clk, wait 100 clk, restart → the next tick arrives 5 clk after restart (prescaler held). i_clear with a coincident tick → all 0.
- Assert rst low mid-count for one clk asynchronously → outputs 0 immediately, o_lap_active=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch datapath.
//   MSEC_W/SEC_W/MIN_W/HOUR_W : field widths of the displayed time
//   SEC_COUNT/MIN_COUNT       : fixed moduli of the sec and min fields
//   mode_e                    : count direction encoding (0 = up, 1 = down)
package stopwatch_pkg;
   localparam int MSEC_W    = 7;
   localparam int SEC_W     = 6;
   localparam int MIN_W     = 6;
   localparam int HOUR_W    = 5;
   localparam int SEC_COUNT = 60;
   localparam int MIN_COUNT = 60;

   typedef enum logic {
      MODE_UP   = 1'b0,
      MODE_DOWN = 1'b1
   } mode_e;
endpackage

// File: rtl/sw_updown_counter.sv
// One modulo-COUNT field of the stopwatch, counting up or down on i_tick.
//   clk, rst   : clock, asynchronous active-low reset
//   i_tick     : advance one step this cycle
//   i_dir      : MODE_UP / MODE_DOWN
//   i_clear    : zero the field (highest priority)
//   i_load     : take i_ld_val, clamped to COUNT-1
//   o_val      : current value
//   o_carry    : up wrap or down borrow on this tick (combinational)
module sw_updown_counter
   import stopwatch_pkg::*;
#(
   parameter int BIT_WIDTH = 7,
   parameter int COUNT     = 100
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_tick,
   input  logic                 i_dir,
   input  logic                 i_clear,
   input  logic                 i_load,
   input  logic [BIT_WIDTH-1:0] i_ld_val,
   output logic [BIT_WIDTH-1:0] o_val,
   output logic                 o_carry
);
   localparam logic [BIT_WIDTH-1:0] MAX_VAL = BIT_WIDTH'(COUNT - 1);
   localparam logic [BIT_WIDTH-1:0] ONE     = BIT_WIDTH'(1);

   logic [BIT_WIDTH-1:0] val_reg;
   logic [BIT_WIDTH-1:0] val_next;
   logic [BIT_WIDTH-1:0] ld_clamped;
   logic                 at_top;
   logic                 at_zero;
   logic                 is_down;

   assign is_down    = (i_dir == MODE_DOWN);
   assign at_top     = (val_reg == MAX_VAL);
   assign at_zero    = (val_reg == '0);
   assign ld_clamped = (i_ld_val > MAX_VAL) ? MAX_VAL : i_ld_val;
   assign o_carry    = i_tick & (is_down ? at_zero : at_top);
   assign o_val      = val_reg;

   always_comb begin
      val_next = val_reg;
      if (i_clear) begin
         val_next = '0;
      end else if (i_load) begin
         val_next = ld_clamped;
      end else if (i_tick) begin
         if (is_down) begin
            val_next = at_zero ? MAX_VAL : (val_reg - ONE);
         end else begin
            val_next = at_top ? '0 : (val_reg + ONE);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         val_reg <= '0;
      end else begin
         val_reg <= val_next;
      end
   end
endmodule

// File: rtl/stopwatch_dp2.sv
// Stopwatch / countdown timer datapath: prescaled tick, cascaded
// msec/sec/min/hour fields, countdown saturation with done pulse, lap freeze.
//   clk, rst            : clock, asynchronous active-low reset
//   i_runstop           : 1 = prescaler (and so counting) enabled
//   i_clear, i_load     : pulses; clear zeroes everything, load takes presets
//   i_mode              : 0 = count up, 1 = count down
//   i_lap               : pulse; toggles output freeze
//   i_ld_*              : preset fields (clamped to each field's modulus-1)
//   msec/sec/min/hour   : displayed time (snapshot while frozen, else live)
//   o_lap_active        : outputs frozen
//   o_done              : one-cycle pulse when a countdown lands on zero
module stopwatch_dp2
   import stopwatch_pkg::*;
#(
   parameter int SYS_CLK_HZ = 100_000_000,
   parameter int TICK_HZ    = 100,
   parameter int MSEC_COUNT = 100,
   parameter int HOUR_COUNT = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_runstop,
   input  logic              i_clear,
   input  logic              i_mode,
   input  logic              i_load,
   input  logic              i_lap,
   input  logic [MSEC_W-1:0] i_ld_msec,
   input  logic [SEC_W-1:0]  i_ld_sec,
   input  logic [MIN_W-1:0]  i_ld_min,
   input  logic [HOUR_W-1:0] i_ld_hour,
   output logic [MSEC_W-1:0] msec,
   output logic [SEC_W-1:0]  sec,
   output logic [MIN_W-1:0]  min,
   output logic [HOUR_W-1:0] hour,
   output logic              o_lap_active,
   output logic              o_done
);
   localparam int DIV   = SYS_CLK_HZ / TICK_HZ;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
   localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

   // ---------------- prescaler ----------------
   logic [PRE_W-1:0] presc_reg;
   logic [PRE_W-1:0] presc_next;
   logic             tick;

   // Qualified by i_runstop so a prescaler parked at DIV-1 does not tick.
   assign tick = i_runstop & (presc_reg == PRE_MAX);

   always_comb begin
      presc_next = presc_reg;
      if (i_clear || i_load) begin
         presc_next = '0;
      end else if (i_runstop) begin
         presc_next = tick ? '0 : (presc_reg + PRE_ONE);
      end
   end

   // ---------------- counter chain ----------------
   logic [MSEC_W-1:0] live_msec;
   logic [SEC_W-1:0]  live_sec;
   logic [MIN_W-1:0]  live_min;
   logic [HOUR_W-1:0] live_hour;
   logic              msec_carry;
   logic              sec_carry;
   logic              min_carry;
   logic              hour_carry_unused;
   logic              is_down;
   logic              all_zero;
   logic              cnt_tick;

   assign is_down  = (i_mode == MODE_DOWN);
   assign all_zero = (live_msec == '0) && (live_sec == '0) &&
                     (live_min == '0) && (live_hour == '0);
   // Countdown saturates at zero: ticks are swallowed once everything is 0.
   assign cnt_tick = tick & ~(is_down & all_zero);

   sw_updown_counter #(.BIT_WIDTH(MSEC_W), .COUNT(MSEC_COUNT)) u_msec (
      .clk(clk), .rst(rst), .i_tick(cnt_tick), .i_dir(i_mode),
      .i_clear(i_clear), .i_load(i_load), .i_ld_val(i_ld_msec),
      .o_val(live_msec), .o_carry(msec_carry)
   );

   sw_updown_counter #(.BIT_WIDTH(SEC_W), .COUNT(SEC_COUNT)) u_sec (
      .clk(clk), .rst(rst), .i_tick(msec_carry), .i_dir(i_mode),
      .i_clear(i_clear), .i_load(i_load), .i_ld_val(i_ld_sec),
      .o_val(live_sec), .o_carry(sec_carry)
   );

   sw_updown_counter #(.BIT_WIDTH(MIN_W), .COUNT(MIN_COUNT)) u_min (
      .clk(clk), .rst(rst), .i_tick(sec_carry), .i_dir(i_mode),
      .i_clear(i_clear), .i_load(i_load), .i_ld_val(i_ld_min),
      .o_val(live_min), .o_carry(min_carry)
   );

   // Hour rollover is silent, so its carry goes nowhere.
   sw_updown_counter #(.BIT_WIDTH(HOUR_W), .COUNT(HOUR_COUNT)) u_hour (
      .clk(clk), .rst(rst), .i_tick(min_carry), .i_dir(i_mode),
      .i_clear(i_clear), .i_load(i_load), .i_ld_val(i_ld_hour),
      .o_val(live_hour), .o_carry(hour_carry_unused)
   );

   // ---------------- done pulse ----------------
   // The only down step that lands on all-zero is from 00:00:00.01.
   logic done_reg;
   logic done_next;

   assign done_next = cnt_tick & is_down & ~i_clear & ~i_load &
                      (live_msec == MSEC_W'(1)) && (live_sec == '0) &&
                      (live_min == '0) && (live_hour == '0);

   // ---------------- lap snapshot ----------------
   logic              lap_reg;
   logic [MSEC_W-1:0] snap_msec_reg;
   logic [SEC_W-1:0]  snap_sec_reg;
   logic [MIN_W-1:0]  snap_min_reg;
   logic [HOUR_W-1:0] snap_hour_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_reg     <= '0;
         done_reg      <= 1'b0;
         lap_reg       <= 1'b0;
         snap_msec_reg <= '0;
         snap_sec_reg  <= '0;
         snap_min_reg  <= '0;
         snap_hour_reg <= '0;
      end else begin
         presc_reg <= presc_next;
         done_reg  <= done_next;
         if (i_clear) begin
            lap_reg       <= 1'b0;
            snap_msec_reg <= '0;
            snap_sec_reg  <= '0;
            snap_min_reg  <= '0;
            snap_hour_reg <= '0;
         end else if (i_lap) begin
            // Live registers still hold the pre-tick value on a tick edge.
            if (!lap_reg) begin
               snap_msec_reg <= live_msec;
               snap_sec_reg  <= live_sec;
               snap_min_reg  <= live_min;
               snap_hour_reg <= live_hour;
            end
            lap_reg <= ~lap_reg;
         end
      end
   end

   assign msec         = lap_reg ? snap_msec_reg : live_msec;
   assign sec          = lap_reg ? snap_sec_reg  : live_sec;
   assign min          = lap_reg ? snap_min_reg  : live_min;
   assign hour         = lap_reg ? snap_hour_reg : live_hour;
   assign o_lap_active = lap_reg;
   assign o_done       = done_reg;
endmodule

// File: tb/tb_stopwatch_dp2.sv
// Directed bench for stopwatch_dp2 with DIV = 1000/100 = 10 clocks per tick.
module tb_stopwatch_dp2;
   logic       clk;
   logic       rst;
   logic       i_runstop;
   logic       i_clear;
   logic       i_mode;
   logic       i_load;
   logic       i_lap;
   logic [6:0] i_ld_msec;
   logic [5:0] i_ld_sec;
   logic [5:0] i_ld_min;
   logic [4:0] i_ld_hour;
   logic [6:0] msec;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic       o_lap_active;
   logic       o_done;

   int total = 0;
   int bad   = 0;

   stopwatch_dp2 #(
      .SYS_CLK_HZ(1000),
      .TICK_HZ   (100),
      .MSEC_COUNT(100),
      .HOUR_COUNT(24)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_runstop   (i_runstop),
      .i_clear     (i_clear),
      .i_mode      (i_mode),
      .i_load      (i_load),
      .i_lap       (i_lap),
      .i_ld_msec   (i_ld_msec),
      .i_ld_sec    (i_ld_sec),
      .i_ld_min    (i_ld_min),
      .i_ld_hour   (i_ld_hour),
      .msec        (msec),
      .sec         (sec),
      .min         (min),
      .hour        (hour),
      .o_lap_active(o_lap_active),
      .o_done      (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_time(input string tag, input int h, input int m, input int s, input int ms);
      chk({tag, "_hour"}, hour, h);
      chk({tag, "_min"},  min,  m);
      chk({tag, "_sec"},  sec,  s);
      chk({tag, "_msec"}, msec, ms);
   endtask

   initial begin
      int pulses;
      rst = 1'b0;
      i_runstop = 1'b0; i_clear = 1'b0; i_mode = 1'b0;
      i_load = 1'b0; i_lap = 1'b0;
      i_ld_msec = '0; i_ld_sec = '0; i_ld_min = '0; i_ld_hour = '0;

      // Reset state
      step(2);
      chk_time("rst", 0, 0, 0, 0);
      chk("rst_lap", o_lap_active, 0);
      chk("rst_done", o_done, 0);

      // Up count: first tick on the 10th clock, 1000 clocks = 1.00 s
      rst = 1'b1; i_runstop = 1'b1;
      step(9);
      chk("up_pre_tick_msec", msec, 0);
      step(1);
      chk("up_first_tick_msec", msec, 1);
      step(990);
      chk_time("up_1s", 0, 0, 1, 0);

      // Out-of-range presets clamp to 23:59:59.99, then full rollover
      i_runstop = 1'b0;
      i_ld_hour = 5'd30; i_ld_min = 6'd60; i_ld_sec = 6'd62; i_ld_msec = 7'd120;
      i_load = 1'b1; step(1); i_load = 1'b0;
      chk_time("clamp", 23, 59, 59, 99);
      i_runstop = 1'b1;
      step(10);
      chk_time("rollover", 0, 0, 0, 0);
      chk("rollover_done", o_done, 0);

      // Countdown from 00:00:00.03
      i_runstop = 1'b0; i_mode = 1'b1;
      i_ld_hour = '0; i_ld_min = '0; i_ld_sec = '0; i_ld_msec = 7'd3;
      i_load = 1'b1; step(1); i_load = 1'b0;
      chk("dn_load_msec", msec, 3);
      chk("dn_load_done", o_done, 0);
      i_runstop = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(9);
         chk("dn_pre_tick_done", o_done, 0);
         step(1);
         chk("dn_msec", msec, 2 - k);
         chk("dn_done", o_done, (k == 2) ? 1 : 0);
      end
      pulses = 0;
      for (int c = 0; c < 30; c++) begin
         step(1);
         if (o_done) pulses++;
      end
      chk("dn_sat_pulses", pulses, 0);
      chk_time("dn_sat", 0, 0, 0, 0);

      // Lap coincident with the tick that makes 2.00 -> snapshot 1.99
      i_mode = 1'b0;
      i_clear = 1'b1; step(1); i_clear = 1'b0;
      chk_time("clr", 0, 0, 0, 0);
      step(1999);
      i_lap = 1'b1; step(1); i_lap = 1'b0;
      chk("lap_on", o_lap_active, 1);
      chk_time("lap_snap", 0, 0, 1, 99);
      step(500);
      chk_time("lap_frozen", 0, 0, 1, 99);
      i_lap = 1'b1; step(1); i_lap = 1'b0;
      chk("lap_off", o_lap_active, 0);
      chk_time("lap_live", 0, 0, 2, 50);

      // Prescaler holds while stopped
      i_clear = 1'b1; step(1); i_clear = 1'b0;
      step(5);
      i_runstop = 1'b0;
      step(100);
      chk("stop_msec", msec, 0);
      i_runstop = 1'b1;
      step(4);
      chk("restart_pre_tick", msec, 0);
      step(1);
      chk("restart_tick", msec, 1);

      // Clear wins over a coincident tick, prescaler restarts from 0
      step(9);
      i_clear = 1'b1; step(1); i_clear = 1'b0;
      chk_time("clr_vs_tick", 0, 0, 0, 0);
      step(9);
      chk("clr_presc_pre", msec, 0);
      step(1);
      chk("clr_presc_tick", msec, 1);

      // Load wins over a coincident tick
      step(9);
      i_ld_hour = '0; i_ld_min = '0; i_ld_sec = 6'd5; i_ld_msec = 7'd7;
      i_load = 1'b1; step(1); i_load = 1'b0;
      chk_time("load_vs_tick", 0, 0, 5, 7);

      // Asynchronous reset mid-cycle clears outputs and lap at once
      i_lap = 1'b1; step(1); i_lap = 1'b0;
      chk("pre_rst_lap", o_lap_active, 1);
      #2;
      rst = 1'b0;
      #1;
      chk_time("async_rst", 0, 0, 0, 0);
      chk("async_rst_lap", o_lap_active, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      step(2);
      chk("post_rst_msec", msec, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
